// File: rtl/fpu_issue_if.sv
// Execute-stage request, FPU unit start/result and hazard signals for fpu_issue_ctrl.
// slave = controller side, master = execute stage plus FPU units (the bench).
interface fpu_issue_if;
  logic        req_valid;
  logic        req_slow;
  logic [4:0]  req_funct5;
  logic [2:0]  req_rm;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [31:0] req_rs3;
  logic        flush_e;
  logic        pipe_advance;
  logic        fast_fpu_valid;
  logic [31:0] fast_fpu_result;
  logic        slow_fpu_valid;
  logic [31:0] slow_fpu_result;
  logic        fast_fpu_en;
  logic        slow_fpu_en;
  logic [31:0] fpu_rd1;
  logic [31:0] fpu_rd2;
  logic [31:0] fpu_rd3;
  logic [2:0]  fpu_rm;
  logic [4:0]  fpu_funct5;
  logic        fpu_stall;
  logic        result_valid;
  logic [31:0] result;
  logic        timeout_err;

  modport slave (
    input  req_valid, req_slow, req_funct5, req_rm, req_rs1, req_rs2, req_rs3,
    input  flush_e, pipe_advance,
    input  fast_fpu_valid, fast_fpu_result, slow_fpu_valid, slow_fpu_result,
    output fast_fpu_en, slow_fpu_en, fpu_rd1, fpu_rd2, fpu_rd3, fpu_rm, fpu_funct5,
    output fpu_stall, result_valid, result, timeout_err
  );

  modport master (
    output req_valid, req_slow, req_funct5, req_rm, req_rs1, req_rs2, req_rs3,
    output flush_e, pipe_advance,
    output fast_fpu_valid, fast_fpu_result, slow_fpu_valid, slow_fpu_result,
    input  fast_fpu_en, slow_fpu_en, fpu_rd1, fpu_rd2, fpu_rd3, fpu_rm, fpu_funct5,
    input  fpu_stall, result_valid, result, timeout_err
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issues one FP op at a time to the fast/slow FPU; result_valid 3 cycles after accept for a 1-cycle unit.
// Stalls the hazard unit while an op is outstanding; holds the result in DONE until pipe_advance/flush_e.
module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic       clk,
  input  logic       rst,
  fpu_issue_if.slave io
);

  typedef enum logic [2:0] {IDLE, WAIT_F, WAIT_S, DONE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            first_q, first_d;
  logic            slow_q;
  logic            load;
  logic            to_hit;
  logic            unit_vld;
  logic [31:0]     unit_res;
  logic [31:0]     res_q, res_d;
  logic            terr_q, terr_d;
  logic            stall;
  logic [31:0]     rd1_q, rd2_q, rd3_q;
  logic [2:0]      rm_q;
  logic [4:0]      f5_q;

  assign cnt_inc  = cnt_q + TO_W'(1);
  // >= rather than == so a flush landing on the timeout cycle still ends DRAIN
  assign to_hit   = (cnt_q >= TO_W'(TIMEOUT_CYCLES - 1));
  assign unit_vld = slow_q ? io.slow_fpu_valid : io.fast_fpu_valid;
  assign unit_res = slow_q ? io.slow_fpu_result : io.fast_fpu_result;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    load    = 1'b0;
    res_d   = res_q;
    terr_d  = terr_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = io.req_valid & ~io.flush_e;
        if (io.req_valid && !io.flush_e) begin
          load    = 1'b1;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = io.req_slow ? WAIT_S : WAIT_F;
        end
      end
      WAIT_F, WAIT_S: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (io.flush_e) begin
          state_d = unit_vld ? IDLE : DRAIN;
        end else if (unit_vld) begin
          res_d   = unit_res;
          state_d = DONE;
        end else if (to_hit) begin
          res_d   = '0;
          terr_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.pipe_advance || io.flush_e) state_d = IDLE;
      end
      DRAIN: begin
        stall = io.req_valid;
        cnt_d = cnt_inc;
        if (unit_vld || to_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      slow_q  <= 1'b0;
      res_q   <= '0;
      terr_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rd3_q   <= '0;
      rm_q    <= '0;
      f5_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      res_q   <= res_d;
      terr_q  <= terr_d;
      if (load) begin
        slow_q <= io.req_slow;
        rd1_q  <= io.req_rs1;
        rd2_q  <= io.req_rs2;
        rd3_q  <= io.req_rs3;
        rm_q   <= io.req_rm;
        f5_q   <= io.req_funct5;
      end
    end
  end

  assign io.fast_fpu_en  = (state_q == WAIT_F) & first_q;
  assign io.slow_fpu_en  = (state_q == WAIT_S) & first_q;
  assign io.fpu_rd1      = rd1_q;
  assign io.fpu_rd2      = rd2_q;
  assign io.fpu_rd3      = rd3_q;
  assign io.fpu_rm       = rm_q;
  assign io.fpu_funct5   = f5_q;
  assign io.fpu_stall    = stall;
  assign io.result_valid = (state_q == DONE);
  assign io.result       = res_q;
  assign io.timeout_err  = terr_q;

endmodule
